load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits directly upstream of DataMemory and converts pipeline memory requests into word-wide DataMemory accesses. Supports RISC-V style byte, halfword and word loads and stores: sign/zero extension on loads, read-modify-write for sub-word stores, and misalignment detection. Issues one request at a time and returns one response pulse per accepted request.

Parameters:
ADDR_W, 32, width of the byte address from the pipeline
MEM_ADDR_W, 32, width of the word address driven to DataMemory

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  0=LB/SB, 1=LH/SH, 2=LW/SW, 4=LBU, 5=LHU
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal request, qualified by resp_valid
mem_address  output  MEM_ADDR_W  word address = req_addr[ADDR_W-1:2], zero-extended
mem_write_data  output  32  full word to write
mem_read  output  1  read strobe
mem_write  output  1  write strobe
mem_read_data  input  32  DataMemory read data, valid the cycle after mem_read

Behaviour:
- Reset (async, rst_n low): state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; mem_read=0, mem_write=0, mem_address=0, mem_write_data=0. Strobes drop immediately. A write interrupted by reset is abandoned and no partial write is issued.
- The handshake completes at a rising edge with req_valid && req_ready. At that edge the block latches addr, funct3, we and wdata.
- Error check at accept: funct3 in {3,6,7}; halfword with addr[0]=1; word with addr[1:0]!=0; store with funct3 in {4,5}. On error go to RESP with resp_err=1. No memory strobe is issued.
- States: IDLE, RD, CAP, WR, RESP.
- IDLE -> RD for loads, SB and SH. IDLE -> WR for SW. IDLE -> RESP on error.
- RD: mem_read=1 for exactly one cycle, with mem_address driven. Next state is CAP.
- CAP: capture mem_read_data. A load goes to RESP with extracted data. SB/SH go to WR with the merged word.
- Load extraction:
  - Byte k = addr[1:0] gives bits [8k+7:8k].
  - Halfword at addr[1]: bits [15:0] or [31:16].
  - LB/LH sign-extend. LBU/LHU zero-extend.
- Store merge:
  - SB replaces byte k with wdata[7:0].
  - SH replaces halfword addr[1] with wdata[15:0].
  - All other bits are unchanged.
- WR: mem_write=1 for exactly one cycle, with mem_write_data = merged word (SW: wdata). Next state is RESP.
- RESP: resp_valid=1 for one cycle (no backpressure). Next state is IDLE. req_ready returns high the following cycle.
- Latency from the accept edge to the cycle in which resp_valid is high:
  - error: 1 cycle
  - SW: 2 cycles
  - load: 3 cycles
  - SB/SH: 4 cycles
- mem_read and mem_write are never high in the same cycle. Outside RD/WR both are 0, and mem_address holds its last value.
- resp_rdata and resp_err are 0 whenever resp_valid=0.

Optional Feature:
LSU_PERF_CNT_EN: adds output ports load_count[31:0] and store_count[31:0]. Each increments by one on every successful (non-error) load or store response, wraps modulo 2^32, and resets to 0. Without the macro both ports exist and are tied to 0.

Test Plan:
- SW addr=0x50 wdata=0xABCDEFFA -> mem_write one cycle, mem_address=20, mem_write_data=0xABCDEFFA; resp_valid 2 cycles after accept; err=0.
- Memory word 20 = 0xABCDEFFA. LB addr=0x53 -> rdata 0xFFFFFFAB. LBU addr=0x53 -> 0x000000AB. LH addr=0x50 -> 0xFFFFEFFA. LW -> 0xABCDEFFA. Each response arrives 3 cycles after accept.
- SB addr=0x51 wdata=0x00000012 onto 0xABCDEFFA -> read then write 0xABCD12FA; resp after 4 cycles; then LW addr=0x50 -> 0xABCD12FA.
- LW addr=0x52, SH addr=0x01, funct3=3 -> each returns resp_err=1, rdata=0, 1 cycle latency, with no mem_read/mem_write pulse.
- Assert rst_n low during the RD cycle of an SB -> mem_read drops immediately and no mem_write occurs. After release, req_ready=1 and memory is unchanged.
- With LSU_PERF_CNT_EN: 3 loads, 2 stores, 1 error -> load_count=3, store_count=2.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word pipeline requests into one-at-a-time word accesses to DataMemory.
// Optional `LSU_PERF_CNT_EN adds live load/store completion counters; otherwise both counter ports read 0.
module load_store_unit #(
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [31:0]           mem_read_data,
    output logic [31:0]           load_count,
    output logic [31:0]           store_count
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      state, state_nx;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic        err_q;
    logic [15:0] wdata_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic        req_err;
    logic        req_sw;
    logic [MEM_ADDR_W-1:0] word_addr;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'd0:    extract = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    extract = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off,
                                          input logic is_half, input logic [15:0] wd);
        logic [31:0] m;
        m = w;
        if (is_half) m[16*off[1] +: 16] = wd;
        else         m[8*off +: 8]      = wd[7:0];
        return m;
    endfunction

    assign accept    = req_valid && req_ready;
    assign req_sw    = req_we && (req_funct3 == 3'd2);
    assign word_addr = MEM_ADDR_W'(req_addr[ADDR_W-1:2]);

    // Illegal encodings, misaligned half/word, and unsigned-store encodings are all rejected at accept.
    assign req_err = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11)
                  || ((req_funct3[1:0] == 2'd1) && req_addr[0])
                  || ((req_funct3 == 3'd2) && (req_addr[1:0] != 2'b00))
                  || (req_we && req_funct3[2]);

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = req_err ? RESP : (req_sw ? WR : RD);
            RD:   state_nx = CAP;
            CAP:  state_nx = we_q ? WR : RESP;
            WR:   state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign req_ready  = (state == IDLE);
    assign mem_read   = (state == RD);
    assign mem_write  = (state == WR);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = ((state == RESP) && !err_q && !we_q) ? rdata_q : 32'b0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            off_q          <= '0;
            f3_q           <= '0;
            we_q           <= 1'b0;
            err_q          <= 1'b0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                off_q   <= req_addr[1:0];
                f3_q    <= req_funct3;
                we_q    <= req_we;
                err_q   <= req_err;
                wdata_q <= req_wdata[15:0];
                if (!req_err) mem_address <= word_addr;
                if (!req_err && req_sw) mem_write_data <= req_wdata;
            end
            if (state == CAP) begin
                if (we_q) mem_write_data <= merge(mem_read_data, off_q, f3_q[0], wdata_q);
                else      rdata_q        <= extract(mem_read_data, off_q, f3_q);
            end
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_count  <= '0;
            store_count <= '0;
        end else if ((state == RESP) && !err_q) begin
            if (we_q) store_count <= store_count + 32'd1;
            else      load_count  <= load_count + 32'd1;
        end
    end
`else
    assign load_count  = 32'b0;
    assign store_count = 32'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a small word memory model answers strobes, and
// expected responses are queued per request and compared when the response pulse appears.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data = '0;
    logic [31:0] load_count;
    logic [31:0] store_count;

    logic [31:0] mem [64];

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
        logic [1:0]  rd_n;
        logic [1:0]  wr_n;
        logic        leak;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
        logic [1:0]  rd_n;
        logic [1:0]  wr_n;
    } vec_t;

    resp_t exp_q [$];

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
        .load_count(load_count), .store_count(store_count)
    );

    always #5 clk = ~clk;

    // DataMemory model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_read)  mem_read_data <= mem[mem_address[5:0]];
        if (mem_write) mem[mem_address[5:0]] <= mem_write_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic resp_t expect_of(input vec_t v);
        resp_t r;
        r.ready = 1'b1;
        r.rdata = v.rdata;
        r.err   = v.err;
        r.lat   = v.lat;
        r.rd_n  = v.rd_n;
        r.wr_n  = v.wr_n;
        r.leak  = 1'b0;
        return r;
    endfunction

    // Drives one request and observes latency, strobe counts and the response fields.
    task automatic run_req(input vec_t v, output resp_t got, output logic [31:0] wr_addr,
                           output logic [31:0] wr_data);
        int   lat;
        int   rd_n;
        int   wr_n;
        logic leak;
        @(negedge clk);
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        got.ready  = req_ready;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; rd_n = 0; wr_n = 0; leak = 1'b0; wr_addr = '0; wr_data = '0;
        while (!resp_valid && lat < 15) begin
            if (mem_read) rd_n++;
            if (mem_write) begin
                wr_n++;
                wr_addr = mem_address;
                wr_data = mem_write_data;
            end
            if (mem_read && mem_write) leak = 1'b1;
            if (resp_rdata !== 32'b0 || resp_err !== 1'b0) leak = 1'b1;
            @(negedge clk);
            lat++;
        end
        got.rdata = resp_rdata;
        got.err   = resp_err;
        got.lat   = 4'(lat);
        got.rd_n  = 2'(rd_n);
        got.wr_n  = 2'(wr_n);
        got.leak  = leak;
    endtask

    task automatic test_reset;
        logic [135:0] obs;
        logic [135:0] want;
        repeat (2) @(negedge clk);
        obs  = {req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write,
                mem_address, mem_write_data, load_count[3:0], store_count[3:0]};
        want = {1'b1, 1'b0, 32'b0, 1'b0, 1'b0, 1'b0, 32'b0, 32'b0, 4'b0, 4'b0};
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL reset_state: got %h, expected %h", obs, want);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_store_word;
        vec_t  t = '{1'b1, 3'd2, 32'h50, 32'hABCDEFFA, 32'h0, 1'b0, 4'd2, 2'd0, 2'd1};
        resp_t got, exp;
        logic [31:0] wa, wd;
        exp_q.push_back(expect_of(t));
        run_req(t, got, wa, wd);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL sw_resp: got %p, expected %p", got, exp);
        end
        vectors++;
        if ({wa, wd} !== {32'd20, 32'hABCDEFFA}) begin
            miscompares++;
            $display("FAIL sw_mem_access: got addr %0d data %h, expected addr 20 data abcdeffa", wa, wd);
        end
    endtask

    task automatic test_loads;
        vec_t t [4] = '{
            '{1'b0, 3'd0, 32'h53, 32'h0, 32'hFFFFFFAB, 1'b0, 4'd3, 2'd1, 2'd0},
            '{1'b0, 3'd4, 32'h53, 32'h0, 32'h000000AB, 1'b0, 4'd3, 2'd1, 2'd0},
            '{1'b0, 3'd1, 32'h50, 32'h0, 32'hFFFFEFFA, 1'b0, 4'd3, 2'd1, 2'd0},
            '{1'b0, 3'd2, 32'h50, 32'h0, 32'hABCDEFFA, 1'b0, 4'd3, 2'd1, 2'd0}};
        resp_t got, exp;
        logic [31:0] wa, wd;
        foreach (t[i]) begin
            exp_q.push_back(expect_of(t[i]));
            run_req(t[i], got, wa, wd);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL load[%0d]: got %p, expected %p", i, got, exp);
            end
        end
    endtask

    task automatic test_sub_word_store;
        vec_t t [2] = '{
            '{1'b1, 3'd0, 32'h51, 32'h00000012, 32'h0,        1'b0, 4'd4, 2'd1, 2'd1},
            '{1'b0, 3'd2, 32'h50, 32'h0,        32'hABCD12FA, 1'b0, 4'd3, 2'd1, 2'd0}};
        resp_t got, exp;
        logic [31:0] wa, wd;
        foreach (t[i]) begin
            exp_q.push_back(expect_of(t[i]));
            run_req(t[i], got, wa, wd);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL sb_seq[%0d]: got %p, expected %p", i, got, exp);
            end
            if (i == 0) begin
                vectors++;
                if ({wa, wd} !== {32'd20, 32'hABCD12FA}) begin
                    miscompares++;
                    $display("FAIL sb_merge: got addr %0d data %h, expected addr 20 data abcd12fa", wa, wd);
                end
            end
        end
    endtask

    task automatic test_errors;
        vec_t t [4] = '{
            '{1'b0, 3'd2, 32'h52, 32'h0, 32'h0, 1'b1, 4'd1, 2'd0, 2'd0},
            '{1'b1, 3'd1, 32'h01, 32'h0, 32'h0, 1'b1, 4'd1, 2'd0, 2'd0},
            '{1'b0, 3'd3, 32'h50, 32'h0, 32'h0, 1'b1, 4'd1, 2'd0, 2'd0},
            '{1'b1, 3'd4, 32'h50, 32'h5, 32'h0, 1'b1, 4'd1, 2'd0, 2'd0}};
        resp_t got, exp;
        logic [31:0] wa, wd;
        foreach (t[i]) begin
            exp_q.push_back(expect_of(t[i]));
            run_req(t[i], got, wa, wd);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL err[%0d]: got %p, expected %p", i, got, exp);
            end
        end
        vectors++;
        if (mem[20] !== 32'hABCD12FA) begin
            miscompares++;
            $display("FAIL err_mem_untouched: got %h, expected abcd12fa", mem[20]);
        end
    endtask

    task automatic test_back_to_back;
        vec_t t [4] = '{
            '{1'b1, 3'd1, 32'h52, 32'h00001234, 32'h0,        1'b0, 4'd4, 2'd1, 2'd1},
            '{1'b0, 3'd5, 32'h52, 32'h0,        32'h00001234, 1'b0, 4'd3, 2'd1, 2'd0},
            '{1'b0, 3'd4, 32'h50, 32'h0,        32'h000000FA, 1'b0, 4'd3, 2'd1, 2'd0},
            '{1'b0, 3'd2, 32'h50, 32'h0,        32'h123412FA, 1'b0, 4'd3, 2'd1, 2'd0}};
        resp_t got, exp;
        logic [31:0] wa, wd;
        foreach (t[i]) begin
            exp_q.push_back(expect_of(t[i]));
            run_req(t[i], got, wa, wd);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got %p, expected %p", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] snap;
        int          wr_seen;
        snap    = mem[20];
        wr_seen = 0;
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h51; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        vectors++;
        if (mem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_rd_cycle: mem_read got %b, expected 1", mem_read);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({mem_read, mem_write, req_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL rst_async_drop: rd/wr/ready got %b, expected 001", {mem_read, mem_write, req_ready});
        end
        repeat (3) begin
            @(negedge clk);
            if (mem_write) wr_seen++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (mem_write) wr_seen++;
        end
        vectors++;
        if ({wr_seen == 0, mem[20], req_ready} !== {1'b1, snap, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_abandon: writes %0d mem %h ready %b, expected 0 writes mem %h ready 1",
                     wr_seen, mem[20], req_ready, snap);
        end
    endtask

    task automatic test_perf_counters;
        vec_t t [6] = '{
            '{1'b1, 3'd2, 32'h54, 32'h80000000, 32'h0,        1'b0, 4'd2, 2'd0, 2'd1},
            '{1'b1, 3'd0, 32'h55, 32'h0000007F, 32'h0,        1'b0, 4'd4, 2'd1, 2'd1},
            '{1'b0, 3'd2, 32'h54, 32'h0,        32'h80007F00, 1'b0, 4'd3, 2'd1, 2'd0},
            '{1'b0, 3'd0, 32'h55, 32'h0,        32'h0000007F, 1'b0, 4'd3, 2'd1, 2'd0},
            '{1'b0, 3'd1, 32'h56, 32'h0,        32'hFFFF8000, 1'b0, 4'd3, 2'd1, 2'd0},
            '{1'b1, 3'd5, 32'h54, 32'h1,        32'h0,        1'b1, 4'd1, 2'd0, 2'd0}};
        resp_t got, exp;
        logic [31:0] wa, wd;
        logic [31:0] exp_loads, exp_stores;
`ifdef LSU_PERF_CNT_EN
        exp_loads = 32'd3; exp_stores = 32'd2;
`else
        exp_loads = 32'd0; exp_stores = 32'd0;
`endif
        foreach (t[i]) begin
            exp_q.push_back(expect_of(t[i]));
            run_req(t[i], got, wa, wd);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL perf_seq[%0d]: got %p, expected %p", i, got, exp);
            end
        end
        @(negedge clk);
        vectors++;
        if ({load_count, store_count} !== {exp_loads, exp_stores}) begin
            miscompares++;
            $display("FAIL perf_counts: got loads %0d stores %0d, expected loads %0d stores %0d",
                     load_count, store_count, exp_loads, exp_stores);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_store_word();
        test_loads();
        test_sub_word_store();
        test_errors();
        test_back_to_back();
        test_reset_mid_op();
        test_perf_counters();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
